// File: rtl/matrix_cursor.sv
`default_nettype none
// ============================================================================
// Module      : matrix_cursor
// Description : Cursor controller for an N x N LED matrix. Direction keys
//               move a one-hot cursor (row/column). Holding a key produces
//               one immediate step, a step after REPEAT_DLY cycles, and then
//               a step every REPEAT_RATE cycles. A row-scan generator drives
//               the matrix, lighting the cursor column on the cursor row.
// Ports       : clk        - sole clock, rising edge
//               reset      - synchronous, active-low reset
//               unable     - 1 = movement frozen (scan keeps running)
//               keycode    - 1 left, 2 right, 8 up, 9 down, else no direction
//               key_valid  - 1 = a key is pressed and keycode is meaningful
//               ver        - one-hot cursor row
//               hor        - one-hot cursor column
//               row        - one-hot scan row select
//               red        - registered column drive for the scanned row
// Revision    : 1.0 - initial release
// ============================================================================
module matrix_cursor #(
    parameter int N           = 8,
    parameter int WRAP        = 0,
    parameter int REPEAT_DLY  = 50000,
    parameter int REPEAT_RATE = 10000,
    parameter int SCAN_DIV    = 1000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         unable,
    input  logic [3:0]   keycode,
    input  logic         key_valid,
    output logic [N-1:0] ver,
    output logic [N-1:0] hor,
    output logic [N-1:0] row,
    output logic [N-1:0] red
);

    // ------------------------------------------------------------------------
    // Widths and constants
    // ------------------------------------------------------------------------
    localparam int c_RW   = (N > 1) ? $clog2(N) : 1;
    localparam int c_CMAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
    localparam int c_CW   = $clog2(c_CMAX + 1);
    localparam int c_SW   = $clog2(SCAN_DIV + 1);

    localparam logic [c_RW-1:0] c_LAST      = c_RW'(N - 1);
    localparam logic [c_CW-1:0] c_DLY_LAST  = c_CW'(REPEAT_DLY - 1);
    localparam logic [c_CW-1:0] c_RATE_LAST = c_CW'(REPEAT_RATE - 1);
    localparam logic [c_SW-1:0] c_SCAN_LAST = c_SW'(SCAN_DIV - 1);
    localparam logic [N-1:0]    c_ONE       = N'(1);

    localparam logic [3:0] c_KEY_LEFT  = 4'd1;
    localparam logic [3:0] c_KEY_RIGHT = 4'd2;
    localparam logic [3:0] c_KEY_UP    = 4'd8;
    localparam logic [3:0] c_KEY_DOWN  = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------------
    state_t          r_state, w_state_nxt;
    logic [c_CW-1:0] r_cnt, w_cnt_nxt;
    logic [3:0]      r_code, w_code_nxt;
    logic            w_step;
    logic [c_RW-1:0] r_r, r_c, w_r_nxt, w_c_nxt;
    logic [c_SW-1:0] r_scan_cnt;
    logic [N-1:0]    r_row;
    logic [N-1:0]    r_red;
    logic            w_dir;

    // ------------------------------------------------------------------------
    // Index step helpers: saturate or wrap at the matrix edges
    // ------------------------------------------------------------------------
    function automatic logic [c_RW-1:0] f_dec(input logic [c_RW-1:0] v);
        if (v == '0)
            return (WRAP != 0) ? c_LAST : '0;
        else
            return v - 1'b1;
    endfunction

    function automatic logic [c_RW-1:0] f_inc(input logic [c_RW-1:0] v);
        if (v == c_LAST)
            return (WRAP != 0) ? '0 : c_LAST;
        else
            return v + 1'b1;
    endfunction

    // A key only counts when it is pressed and carries a direction code
    assign w_dir = key_valid && ((keycode == c_KEY_LEFT) || (keycode == c_KEY_RIGHT) ||
                                 (keycode == c_KEY_UP)   || (keycode == c_KEY_DOWN));

    // ------------------------------------------------------------------------
    // Press FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_code  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_code  <= w_code_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Press FSM: next state and step request
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_code_nxt  = r_code;
        w_step      = 1'b0;

        if (unable) begin
            // Frozen: drop back to IDLE so a still-held key restarts as a new press
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_dir) begin
                        w_step      = 1'b1;
                        w_code_nxt  = keycode;
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_DELAY;
                    end
                end
                ST_DELAY, ST_REPEAT: begin
                    if (!w_dir) begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                    end else if (keycode != r_code) begin
                        // Direction changed while held: restart as a fresh press
                        w_step      = 1'b1;
                        w_code_nxt  = keycode;
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_DELAY;
                    end else if (r_cnt == ((r_state == ST_DELAY) ? c_DLY_LAST : c_RATE_LAST)) begin
                        w_step      = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_REPEAT;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Cursor position. A step always moves in the currently held direction,
    // which equals the latched code whenever a repeat fires.
    // ------------------------------------------------------------------------
    always_comb begin
        w_r_nxt = r_r;
        w_c_nxt = r_c;
        if (w_step) begin
            case (keycode)
                c_KEY_LEFT:  w_c_nxt = f_dec(r_c);
                c_KEY_RIGHT: w_c_nxt = f_inc(r_c);
                c_KEY_UP:    w_r_nxt = f_dec(r_r);
                c_KEY_DOWN:  w_r_nxt = f_inc(r_r);
                default:     ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_r <= '0;
            r_c <= '0;
        end else begin
            r_r <= w_r_nxt;
            r_c <= w_c_nxt;
        end
    end

    assign ver = c_ONE << r_r;
    assign hor = c_ONE << r_c;

    // ------------------------------------------------------------------------
    // Row scan and column drive
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_scan_cnt <= '0;
            r_row      <= c_ONE;
            r_red      <= '0;
        end else begin
            if (r_scan_cnt == c_SCAN_LAST) begin
                r_scan_cnt <= '0;
                r_row      <= {r_row[N-2:0], r_row[N-1]};
            end else begin
                r_scan_cnt <= r_scan_cnt + 1'b1;
            end
            // Sampled from the current row/cursor, so red trails them by one cycle
            r_red <= (r_row == ver) ? hor : '0;
        end
    end

    assign row = r_row;
    assign red = r_red;

endmodule
`default_nettype wire
